inst_fetch_stage: RTL
=====================

# inst_fetch_stage

Instruction fetch stage sitting directly upstream of the decode/execute core. Owns the program counter and drives the instruction SRAM read port (synchronous, 1-cycle read latency). Buffers returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake. Accepts branch redirects from execute with zero bubble beyond SRAM latency.

## Interface
- `RESET_PC`, default `32'h1c000000`: first fetch address after reset.
- `DEPTH`, default `2`: instruction buffer entries; power of two, ≥2.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `inst_sram_en`  out  1: read request this cycle.
- `inst_sram_addr`  out  32: read address; meaningful when `inst_sram_en`=1.
- `inst_sram_rdata`  in  32: data for the request issued the previous cycle.
- `br_taken`  in  1: redirect strobe from execute; pre-qualified by caller.
- `br_target`  in  32: redirect address, sampled when `br_taken`=1.
- `fs_valid`  out  1: FIFO head holds an instruction.
- `fs_ready`  in  1: decode accepts head; transfer = `fs_valid & fs_ready`.
- `fs_pc`  out  32: PC of head entry.
- `fs_inst`  out  32: instruction word of head entry.
- `fs_adef`  out  1: sticky misaligned-fetch flag (only with `IF_ALIGN_CHECK_EN`; tied 0 otherwise).

## Operation
- Registers: `fetch_pc` (next address to request), `inflight` (1 bit, request issued last cycle), `inflight_pc`, FIFO of {pc, inst}, `count`.
- Credit: `credit = DEPTH - count - inflight + pop`, where `pop = fs_valid & fs_ready`.
- Issue: `inst_sram_en = (credit > 0) & ~halted`. `inst_sram_addr = br_taken ? br_target : fetch_pc`.
- On issue: `fetch_pc <= inst_sram_addr + 4`, `inflight <= 1`, `inflight_pc <= inst_sram_addr`. No issue and no redirect: `fetch_pc` holds, `inflight <= 0`.
- Response: when `inflight`=1 and no redirect this cycle, push {`inflight_pc`, `inst_sram_rdata`} into FIFO.
- Redirect (`br_taken`=1):
  - FIFO cleared at cycle end; any pop in the same cycle still completes.
  - The response arriving this cycle is dropped.
  - Credit is evaluated as `DEPTH` (post-flush), so a request to `br_target` always issues this cycle.
- Simultaneous push and pop: `count` unchanged; head advances.
- Arithmetic: PC increment is modulo 2^32; `0xfffffffc + 4` wraps to 0.
- Without the align check, `br_target[1:0]` is ignored; the issued address uses `{br_target[31:2], 2'b00}`.

## Timing
- Reset values: `inst_sram_en`=0, `inst_sram_addr`=`RESET_PC`, `fs_valid`=0, `fs_pc`=0, `fs_inst`=0, `fs_adef`=0, `count`=0, `inflight`=0, `fetch_pc`=`RESET_PC`.
- Cycle numbering: cycle 0 is the first cycle with `reset` low.
- Cycle 0: request at `RESET_PC`. Cycle 1: rdata pushed. Cycle 2: `fs_valid`=1.
- Redirect-to-valid latency: 2 cycles (redirect at t, target instruction valid at t+2).
- Sustained throughput: 1 instruction/cycle with `fs_ready` held 1 and `DEPTH`≥2.
- `fs_ready`=0 for ≥2 cycles: FIFO fills to `DEPTH`, then `inst_sram_en`=0. Never overflows.
- `fs_pc`/`fs_inst` read 0 whenever `fs_valid`=0.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight response is discarded.

## Configuration
- `IF_ALIGN_CHECK_EN` defined:
  - `br_taken` with `br_target[1:0]≠0` sets `fs_adef`=1 and `halted`=1, and flushes the FIFO.
  - While halted, no further requests issue. Only reset clears the halt.
  - `fs_pc` then reports the faulting target with `fs_valid`=1 and `fs_inst`=0, so decode can raise ADEF.
- `IF_ALIGN_CHECK_EN` undefined: `fs_adef` tied 0, `halted` constant 0, low target bits masked.

## Structure
- Shared package `if_pkg`:
  - `RESET_PC_DEFAULT` constant.
  - `fetch_entry_t` struct {`pc[31:0]`, `inst[31:0]`}.
- Sub-module `inst_fifo`:
  - Synchronous FIFO of `fetch_entry_t`.
  - Ports: push, pop, flush, count, head.
  - Flush has priority over push; pop and flush may coincide.
- Top holds the PC, inflight tracking and credit logic.

## Test plan
- Release reset, `fs_ready`=1, SRAM returns `addr^32'hA5A5A5A5`:
  - cycle 0 addr 0x1c000000; cycle 2 `fs_pc`=0x1c000000, `fs_inst`=0xb9a5a5a5; one new PC per cycle thereafter.
- Backpressure: `fs_ready`=0 from cycle 2 to cycle 8:
  - `inst_sram_en`=0 by cycle 4, `count`=2.
  - On release, PCs 0x1c000000, 0x1c000004, … in order with no gaps or duplicates.
- Redirect: `br_taken`=1, `br_target`=0x1c000100 in cycle 5, head handshake in the same cycle:
  - cycle 5 `inst_sram_addr`=0x1c000100.
  - cycle 6 `fs_valid`=0.
  - cycle 7 `fs_pc`=0x1c000100.
  - No pre-redirect PC appears after cycle 5.
- Back-to-back redirects to 0x200 then 0x300 in cycles 5 and 6:
  - 0x200 never appears on `fs_pc`.
  - First valid is 0x300 in cycle 8.
- Assert `reset` asynchronously mid-cycle while FIFO is full:
  - `fs_valid`, `inst_sram_en` drop to 0 immediately; restart from 0x1c000000.
- With `IF_ALIGN_CHECK_EN`, `br_target`=0x1c000102:
  - `fs_adef`=1 next cycle.
  - `inst_sram_en` stays 0 until reset.
  - Without the macro, fetch goes to 0x1c000100.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   fetch_entry_t    : one buffered fetch result {pc, inst}
package if_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c00_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of fetch_entry_t holding fetched instructions with their PCs.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   push_i      : write entry_i at the tail (ignored when flush_i)
//   entry_i     : entry to write
//   pop_i       : advance the head
//   flush_i     : empty the FIFO at cycle end; wins over push_i
//   count_o     : number of valid entries
//   head_o      : head entry (contents undefined when count_o == 0)
module inst_fifo
    import if_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push_i,
    input  fetch_entry_t             entry_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output fetch_entry_t             head_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t      mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW:0]       count_q, count_d;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + 1'b1;
            if (pop_i)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wptr_q] <= entry_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: owns the PC, drives the 1-cycle-latency instruction SRAM,
// buffers responses in inst_fifo and hands them to decode over valid/ready.
// Optional feature macro: IF_ALIGN_CHECK_EN (misaligned branch target -> sticky ADEF halt).
// Ports:
//   clk, reset                       : clock, asynchronous active-high reset
//   inst_sram_en / inst_sram_addr    : SRAM read request and address
//   inst_sram_rdata                  : data for last cycle's request
//   br_taken / br_target             : redirect from execute
//   fs_valid / fs_ready              : handshake to decode
//   fs_pc / fs_inst                  : head entry (zero when not valid)
//   fs_adef                          : sticky misaligned-fetch flag
module inst_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_en,
    output logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_rdata,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic        fs_valid,
    input  logic        fs_ready,
    output logic [31:0] fs_pc,
    output logic [31:0] fs_inst,
    output logic        fs_adef
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  inflight_pc_q, inflight_pc_d;
    logic         inflight_q, inflight_d;
    logic [CW-1:0] count;
    fetch_entry_t head, push_entry;
    logic         fifo_valid, push, pop, credit_ok, issue;
    logic         halted, br_bad;
    logic [31:0]  br_addr;

`ifdef IF_ALIGN_CHECK_EN
    logic         halted_q;
    logic [31:0]  adef_pc_q;

    assign br_bad  = br_taken & (|br_target[1:0]);
    assign br_addr = br_target;
    assign halted  = halted_q;
    assign fs_adef = halted_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q  <= 1'b0;
            adef_pc_q <= '0;
        end else if (br_bad && !halted_q) begin
            halted_q  <= 1'b1;
            adef_pc_q <= br_target;
        end
    end
`else
    logic unused_tgt_lo;

    assign br_bad        = 1'b0;
    assign br_addr       = {br_target[31:2], 2'b00};
    assign halted        = 1'b0;
    assign fs_adef       = 1'b0;
    assign unused_tgt_lo = ^br_target[1:0];
`endif

    assign fifo_valid = (count != '0);
    assign pop        = fifo_valid & fs_ready & ~halted;

    // A redirect flushes the FIFO and drops the inflight response, so full credit is available.
    // Otherwise: DEPTH - count - inflight + pop > 0.
    assign credit_ok = br_taken |
                       ((32'(count) + 32'(inflight_q)) < (DEPTH + 32'(pop)));

    // Gating with reset keeps the request low while reset is held.
    assign issue          = credit_ok & ~halted & ~br_bad & ~reset;
    assign inst_sram_en   = issue;
    assign inst_sram_addr = br_taken ? br_addr : fetch_pc_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_pc_d = inflight_pc_q;
        inflight_d    = 1'b0;
        if (issue) begin
            fetch_pc_d    = inst_sram_addr + 32'd4;
            inflight_pc_d = inst_sram_addr;
            inflight_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
        end
    end

    assign push            = inflight_q & ~br_taken & ~halted;
    assign push_entry.pc   = inflight_pc_q;
    assign push_entry.inst = inst_sram_rdata;

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (br_taken),
        .count_o (count),
        .head_o  (head)
    );

    always_comb begin
        fs_valid = fifo_valid;
        fs_pc    = fifo_valid ? head.pc   : '0;
        fs_inst  = fifo_valid ? head.inst : '0;
`ifdef IF_ALIGN_CHECK_EN
        if (halted_q) begin
            fs_valid = 1'b1;
            fs_pc    = adef_pc_q;
            fs_inst  = '0;
        end
`endif
    end

endmodule
